// File: rtl/bcd_updown_counter_n.sv
// rtl/bcd_updown_counter_n.sv - synchronous multi-digit BCD up/down counter with load, saturate/wrap and terminal count
module bcd_updown_counter_n #(
    parameter int DIGITS   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  d,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  c,
    output logic                  tc
);

    logic [4*DIGITS-1:0] count_q, count_d;
    logic                c_q, c_d;
    logic                all_nine, all_zero;

    // Range-end detection; tc depends only on the count and direction so it can feed a cascade
    always_comb begin
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (count_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
        end
        tc = d ? all_zero : all_nine;
    end

    // Next count: load clamps each digit to 9, counting ripples a step through the decades
    always_comb begin
        logic [3:0] dig;
        logic       step;
        count_d = count_q;
        c_d     = 1'b0;
        dig     = 4'd0;
        step    = 1'b1;
        if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig = load_val[4*i +: 4];
                count_d[4*i +: 4] = (dig > 4'd9) ? 4'd9 : dig;
            end
        end else if (en) begin
            if (tc && SATURATE) begin
                // Blocked at the range end: hold and flag every such cycle
                c_d = 1'b1;
            end else begin
                // A step while tc is high is the wrap, which the carry chain produces naturally
                c_d = tc;
                for (int i = 0; i < DIGITS; i++) begin
                    dig = count_q[4*i +: 4];
                    if (step) begin
                        if (!d) count_d[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                        else    count_d[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                    end
                    step = step & (d ? (dig == 4'd0) : (dig == 4'd9));
                end
            end
        end
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            c_q     <= 1'b0;
        end else begin
            count_q <= count_d;
            c_q     <= c_d;
        end
    end

    assign q = count_q;
    assign c = c_q;

endmodule
